// File: rtl/crc7_pkg.sv
// -----------------------------------------------------------------------------
// crc7_pkg
// Shared definitions for the CRC-7 serial encoder path.
//   CRC_W          : CRC register width (7)
//   POLY_DEFAULT   : generator polynomial x^7+x^3+1 without the x^7 term
//   INIT_DEFAULT   : CRC register value at the start of a frame
//   END_BIT        : constant trailing bit used when CRC7_END_BIT_EN is defined
//   state_t        : encoder FSM states
//   crc7_step*     : one LFSR step absorbing a single data bit
// -----------------------------------------------------------------------------
package crc7_pkg;

  localparam int         CRC_W        = 7;
  localparam logic [6:0] POLY_DEFAULT = 7'h09;
  localparam logic [6:0] INIT_DEFAULT = 7'h00;
  localparam logic       END_BIT      = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    APPEND = 2'd2
  } state_t;

  // One CRC step with an explicit polynomial: shift left, fold in the
  // polynomial when the outgoing MSB differs from the incoming bit.
  function automatic logic [CRC_W-1:0] crc7_step_poly(
    input logic [CRC_W-1:0] crc,
    input logic             d,
    input logic [CRC_W-1:0] poly
  );
    logic fb;
    fb = crc[CRC_W-1] ^ d;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : 7'h00);
  endfunction

  // One CRC step using the default generator polynomial.
  function automatic logic [CRC_W-1:0] crc7_step(
    input logic [CRC_W-1:0] crc,
    input logic             d
  );
    return crc7_step_poly(crc, d, POLY_DEFAULT);
  endfunction

endpackage

// File: rtl/crc7_lfsr.sv
// -----------------------------------------------------------------------------
// crc7_lfsr
// 7-bit CRC register with load-INIT, step and hold controls.
// Ports:
//   clk    in  : rising-edge clock
//   reset  in  : synchronous active-low reset (register returns to INIT)
//   load   in  : restart the register from INIT this cycle
//   step   in  : absorb bit d (when load is also high, d is absorbed on top
//                of INIT, so a frame's first bit costs no extra cycle)
//   d      in  : data bit to absorb
//   crc    out : current register contents
// -----------------------------------------------------------------------------
module crc7_lfsr
  import crc7_pkg::*;
#(
  parameter logic [6:0] POLY = POLY_DEFAULT,
  parameter logic [6:0] INIT = INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic       d,
  output logic [6:0] crc
);

  // CRC register: reset/load to INIT, optionally stepping in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      crc <= INIT;
    end else if (load) begin
      crc <= step ? crc7_step_poly(INIT, d, POLY) : INIT;
    end else if (step) begin
      crc <= crc7_step_poly(crc, d, POLY);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/crc7_serial_encoder.sv
// -----------------------------------------------------------------------------
// crc7_serial_encoder
// Passes a serial payload through while folding it into a CRC-7, then appends
// the CRC MSB-first on the same serial line and reports it in parallel.
// Optional feature macro: CRC7_END_BIT_EN (appends a constant 1 end bit after
// CRC bit 0, making the tail 8 bits).
// Ports:
//   clk        in  : rising-edge clock
//   reset      in  : synchronous active-low reset
//   en_crc     in  : payload window; data_in carries a bit while high
//   data_in    in  : serial payload bit, frame MSB first
//   dout       out : payload bits, then CRC bits (then end bit if enabled)
//   dout_valid out : dout carries a frame bit
//   crc_out    out : CRC of the last completed frame
//   crc_valid  out : one-cycle pulse when crc_out updates
//   busy       out : high while in SHIFT or APPEND
//   overrun    out : one-cycle pulse on a window longer than MAX_BITS or
//                    en_crc raised during the tail (at most once per frame)
// -----------------------------------------------------------------------------
module crc7_serial_encoder
  import crc7_pkg::*;
#(
  parameter int         MAX_BITS = 64,
  parameter logic [6:0] POLY     = POLY_DEFAULT,
  parameter logic [6:0] INIT     = INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_crc,
  input  logic       data_in,
  output logic       dout,
  output logic       dout_valid,
  output logic [6:0] crc_out,
  output logic       crc_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int               CNT_W   = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [2:0]       app_cnt, app_cnt_next;
  logic             crc_sent, crc_sent_next;   // CRC bit 0 already emitted
  logic             ovr_seen, ovr_seen_next;   // overrun already reported this frame
`ifdef CRC7_END_BIT_EN
  logic             end_sent, end_sent_next;
`endif
  logic             tail_done;
  logic             start_frame;
  logic             lfsr_load, lfsr_step;
  logic [6:0]       crc;

  logic             dout_next, dout_valid_next, crc_valid_next;
  logic             busy_next, overrun_next;
  logic [6:0]       crc_out_next;

  crc7_lfsr #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .d     (data_in),
    .crc   (crc)
  );

`ifdef CRC7_END_BIT_EN
  assign tail_done = crc_sent & end_sent;
`else
  assign tail_done = crc_sent;
`endif

  // Next-state, counter and output decode.
  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    app_cnt_next    = app_cnt;
    crc_sent_next   = crc_sent;
    ovr_seen_next   = ovr_seen;
`ifdef CRC7_END_BIT_EN
    end_sent_next   = end_sent;
`endif
    start_frame     = 1'b0;
    lfsr_load       = 1'b0;
    lfsr_step       = 1'b0;
    dout_next       = 1'b0;
    dout_valid_next = 1'b0;
    crc_out_next    = crc_out;
    crc_valid_next  = 1'b0;
    overrun_next    = 1'b0;
    busy_next       = 1'b0;

    case (state)
      IDLE: begin
        if (en_crc) begin
          start_frame = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end

      SHIFT: begin
        if (en_crc) begin
          if (bit_cnt < MAX_CNT) begin
            lfsr_step       = 1'b1;
            dout_next       = data_in;
            dout_valid_next = 1'b1;
            bit_cnt_next    = bit_cnt + CNT_W'(1);
          end else begin
            // Window too long: drop this bit and start the tail next cycle.
            overrun_next  = 1'b1;
            ovr_seen_next = 1'b1;
            app_cnt_next  = 3'd0;
            state_next    = APPEND;
          end
        end else begin
          // Emit CRC bit 6 on the transition so the stream has no gap.
          dout_next       = crc[6];
          dout_valid_next = 1'b1;
          app_cnt_next    = 3'd1;
          state_next      = APPEND;
        end
      end

      APPEND: begin
        if (tail_done) begin
          crc_out_next   = crc;
          crc_valid_next = 1'b1;
          state_next     = IDLE;
          // The return cycle may already carry the next frame's first bit.
          if (en_crc) begin
            start_frame = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (!crc_sent) begin
            dout_next       = crc[3'd6 - app_cnt];
            dout_valid_next = 1'b1;
            if (app_cnt == 3'd6) begin
              crc_sent_next = 1'b1;
            end else begin
              app_cnt_next = app_cnt + 3'd1;
            end
          end else begin
`ifdef CRC7_END_BIT_EN
            dout_next       = END_BIT;
            dout_valid_next = 1'b1;
            end_sent_next   = 1'b1;
`else
            dout_next       = 1'b0;
`endif
          end
          if (en_crc && !ovr_seen) begin
            overrun_next  = 1'b1;
            ovr_seen_next = 1'b1;
          end else begin
            overrun_next  = 1'b0;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (start_frame) begin
      lfsr_load       = 1'b1;
      lfsr_step       = 1'b1;
      dout_next       = data_in;
      dout_valid_next = 1'b1;
      bit_cnt_next    = CNT_W'(1);
      app_cnt_next    = 3'd0;
      crc_sent_next   = 1'b0;
      ovr_seen_next   = 1'b0;
`ifdef CRC7_END_BIT_EN
      end_sent_next   = 1'b0;
`endif
      state_next      = SHIFT;
    end else begin
      lfsr_load       = 1'b0;
    end

    busy_next = (state_next != IDLE);
  end

  // FSM state and frame counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      app_cnt  <= 3'd0;
      crc_sent <= 1'b0;
      ovr_seen <= 1'b0;
`ifdef CRC7_END_BIT_EN
      end_sent <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      app_cnt  <= app_cnt_next;
      crc_sent <= crc_sent_next;
      ovr_seen <= ovr_seen_next;
`ifdef CRC7_END_BIT_EN
      end_sent <= end_sent_next;
`endif
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      crc_out    <= 7'h00;
      crc_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout       <= dout_next;
      dout_valid <= dout_valid_next;
      crc_out    <= crc_out_next;
      crc_valid  <= crc_valid_next;
      busy       <= busy_next;
      overrun    <= overrun_next;
    end
  end

endmodule

// File: tb/tb_crc7_serial_encoder.sv
// -----------------------------------------------------------------------------
// tb_crc7_serial_encoder
// Randomized scoreboard bench. Stimulus pushes expected output events (with the
// cycle they must appear on) into queues; a monitor on the falling edge pops
// and compares them. The CRC reference is a mod-2 long division.
// -----------------------------------------------------------------------------
module tb_crc7_serial_encoder;

  localparam int MAX_BITS = 64;
`ifdef CRC7_END_BIT_EN
  localparam int TAIL = 8;
`else
  localparam int TAIL = 7;
`endif

  typedef logic bitq_t[$];
  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_crc = 1'b0;
  logic       data_in = 1'b0;
  logic       dout, dout_valid, crc_valid, busy, overrun;
  logic [6:0] crc_out;

  int   cyc = 0;
  int   drive_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t bit_q[$];
  exp_t crc_q[$];
  exp_t ovr_q[$];

  crc7_serial_encoder #(
    .MAX_BITS (MAX_BITS),
    .POLY     (7'h09),
    .INIT     (7'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en_crc     (en_crc),
    .data_in    (data_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .crc_out    (crc_out),
    .crc_valid  (crc_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_ev(input string name, input logic [31:0] act, input logic [31:0] exp,
                          input int acyc, input int ecyc);
    checks++;
    if ((act !== exp) || (acyc != ecyc)) begin
      errors++;
      $display("FAIL %s actual=%0h@%0d required=%0h@%0d", name, act, acyc, exp, ecyc);
    end
  endtask

  task automatic pop_check(input string name, inout exp_t q[$], input logic [6:0] act);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected event actual=%0h@%0d required=none", name, act, cyc);
    end else begin
      e = q.pop_front();
      check_ev(name, {25'd0, act}, {25'd0, e.val}, cyc, e.cyc);
    end
  endtask

  // Monitor: compares every presented output event against the scoreboard.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      pop_check("dout_bit", bit_q, {6'd0, dout});
      check_ev("busy_in_frame", {31'd0, busy}, 32'd1, cyc, cyc);
    end else begin
      check_ev("dout_idle_zero", {31'd0, dout}, 32'd0, cyc, cyc);
    end
    if (crc_valid === 1'b1) pop_check("crc_out", crc_q, crc_out);
    if (overrun === 1'b1) pop_check("overrun", ovr_q, 7'd0);
  end

  task automatic step(input logic en, input logic d);
    @(posedge clk);
    #1;
    en_crc    = en;
    data_in   = d;
    drive_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom));
  endtask

  function automatic bitq_t vec40(input logic [39:0] v);
    bitq_t q;
    for (int i = 39; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  // Remainder of M(x)*x^7 divided by x^7+x^3+1 (long division, INIT = 0).
  function automatic logic [6:0] ref_crc(input bitq_t q, input int n);
    logic       w[$];
    logic [7:0] g;
    logic [6:0] r;
    g = 8'h89;
    for (int i = 0; i < n; i++) w.push_back(q[i]);
    for (int i = 0; i < 7; i++) w.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (w[i]) begin
        for (int j = 0; j < 8; j++) w[i+j] = w[i+j] ^ g[7-j];
      end
    end
    for (int j = 0; j < 7; j++) r[6-j] = w[n+j];
    return r;
  endfunction

  // Drives one frame and queues its expected output; returns on the cycle
  // before the tail's final edge so a following frame may start back-to-back.
  task automatic send_frame(input bitq_t q, input int known, input bit pulse);
    int         n;
    int         absorbed;
    int         t;
    int         k;
    bit         ovr;
    logic [6:0] c;
    n        = q.size();
    ovr      = (n > MAX_BITS);
    absorbed = ovr ? MAX_BITS : n;
    t        = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, q[i]);
      if (i < absorbed) bit_q.push_back('{drive_cyc + 1, {6'd0, q[i]}});
      if (i == MAX_BITS) begin
        ovr_q.push_back('{drive_cyc + 1, 7'd0});
        t = drive_cyc + 2;
      end
    end
    if (!ovr) t = drive_cyc + 2;
    c = (known >= 0) ? 7'(known) : ref_crc(q, absorbed);
    for (int j = 0; j < 7; j++) bit_q.push_back('{t + j, {6'd0, c[6-j]}});
`ifdef CRC7_END_BIT_EN
    bit_q.push_back('{t + 7, 7'd1});
`endif
    crc_q.push_back('{t + TAIL, c});
    k = 0;
    while (drive_cyc < t + TAIL - 2) begin
      if (pulse && !ovr && (k == 3 || k == 4)) begin
        step(1'b1, 1'($urandom));
        if (k == 3) ovr_q.push_back('{drive_cyc + 1, 7'd0});
      end else begin
        step(1'b0, 1'($urandom));
      end
      k++;
    end
  endtask

  task automatic check_all_zero(input string name);
    check_ev({name, "_dout"},       {31'd0, dout},       32'd0, cyc, cyc);
    check_ev({name, "_dout_valid"}, {31'd0, dout_valid}, 32'd0, cyc, cyc);
    check_ev({name, "_crc_out"},    {25'd0, crc_out},    32'd0, cyc, cyc);
    check_ev({name, "_crc_valid"},  {31'd0, crc_valid},  32'd0, cyc, cyc);
    check_ev({name, "_busy"},       {31'd0, busy},       32'd0, cyc, cyc);
    check_ev({name, "_overrun"},    {31'd0, overrun},    32'd0, cyc, cyc);
  endtask

  initial begin
    bitq_t q;
    bitq_t one;
    int    len;
    int    gap;

    // Power-on reset.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1;
    reset = 1'b1;
    idle(3);

    // CMD0, CMD8 followed immediately by CMD17-style frame.
    send_frame(vec40(40'h4000000000), 'h4A, 1'b0);
    idle(4);
    send_frame(vec40(40'h48000001AA), 'h43, 1'b0);
    send_frame(vec40(40'h5100000000), 'h2A, 1'b0);
    idle(3);

    // 1-bit windows.
    one = {1'b0};
    send_frame(one, 'h00, 1'b0);
    idle(2);
    one = {1'b1};
    send_frame(one, 'h09, 1'b0);
    idle(2);

    // Window of MAX_BITS+3 bits.
    q = {};
    for (int i = 0; i < MAX_BITS + 3; i++) q.push_back(1'($urandom));
    send_frame(q, -1, 1'b0);
    idle(3);

    // en_crc pulsed during the tail.
    send_frame(vec40(40'h4000000000), 'h4A, 1'b1);
    idle(3);

    // Reset in the middle of a frame at payload bit 20.
    q = vec40(40'h48000001AA);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, q[i]);
      bit_q.push_back('{drive_cyc + 1, {6'd0, q[i]}});
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    en_crc = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midframe_reset");
    idle(12);
    send_frame(vec40(40'h4000000000), 'h4A, 1'b0);
    idle(2);

    // Random frames, sometimes back-to-back.
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, MAX_BITS);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(1'($urandom));
      send_frame(q, -1, 1'b0);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 5);
      idle(gap);
    end

    idle(TAIL + 6);
    @(negedge clk);
    check_ev("bit_q_drained", 32'(bit_q.size()), 32'd0, cyc, cyc);
    check_ev("crc_q_drained", 32'(crc_q.size()), 32'd0, cyc, cyc);
    check_ev("ovr_q_drained", 32'(ovr_q.size()), 32'd0, cyc, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
